// File: rtl/tdm_demux_1to16.sv
// Serial TDM receiver: rebuilds one N-bit word per sof-aligned frame.
// Optional trailing even-parity bit when PARITY_EN is defined.
module tdm_demux_1to16 #(
  parameter int SEL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  input  logic                  din_valid,
  input  logic                  sof,
  output logic [2**SEL_W-1:0]   dout,
  output logic                  dout_valid,
  output logic                  sync_err,
  output logic [SEL_W-1:0]      chan,
  output logic                  par_err
);

  localparam int N = 2**SEL_W;

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_t;
`else
  typedef enum logic {IDLE, COLLECT} state_t;
`endif

  state_t           state_q, state_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [N-1:0]     dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             se_q, se_d;
`ifdef PARITY_EN
  logic             pe_q, pe_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      chan_q   <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      se_q     <= 1'b0;
`ifdef PARITY_EN
      pe_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      se_q     <= se_d;
`ifdef PARITY_EN
      pe_q     <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    dv_d     = 1'b0;
    se_d     = 1'b0;
`ifdef PARITY_EN
    pe_d     = 1'b0;
`endif
    if (din_valid) begin
      // any sof restarts the frame at position 0; mid-frame it is a resync
      if (sof) begin
        se_d        = (state_q != IDLE);
        shadow_d    = '0;
        shadow_d[0] = din;
        chan_d      = SEL_W'(1);
        state_d     = COLLECT;
      end else begin
        case (state_q)
          IDLE: begin
            se_d = 1'b1;
          end
          COLLECT: begin
            shadow_d[chan_q] = din;
            chan_d           = chan_q + SEL_W'(1);
            if (chan_q == SEL_W'(N-1)) begin
`ifdef PARITY_EN
              state_d = PARITY;
`else
              dout_d  = shadow_d;
              dv_d    = 1'b1;
              state_d = IDLE;
`endif
            end
          end
`ifdef PARITY_EN
          PARITY: begin
            dout_d  = shadow_q;
            dv_d    = 1'b1;
            pe_d    = (^shadow_q) ^ din;
            state_d = IDLE;
          end
`endif
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign sync_err   = se_q;
  assign chan       = chan_q;
`ifdef PARITY_EN
  assign par_err    = pe_q;
`else
  assign par_err    = 1'b0;
`endif

endmodule
